tube_ctrl_flags: RTL and testbench

Host-side Tube control-flag register and interrupt/reset sequencer. It holds the seven Tube control flags (Q, I, J, M, V, P, T), which the host writes via the set/clear register protocol. It combines those flags with the data-available status of the R1/R3/R4 byte buffers to drive host IRQ, parasite IRQ and parasite NMI. It also generates the timed FIFO-clear pulse and the parasite reset that sequence the byte buffers.

---
 rtl/tube_ctrl_flags_pkg.sv | 24 ++
 rtl/tube_irq_gen.sv | 43 ++++
 rtl/tube_ctrl_flags.sv | 152 +++++++++++++++
 tb/tb_tube_ctrl_flags.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/tube_ctrl_flags_pkg.sv
// Shared Tube definitions: flag bit positions, reset-sequencer states and
// default timing constants used by the control-flag register.
package tube_ctrl_flags_pkg;

    localparam int FLAG_Q = 0;
    localparam int FLAG_I = 1;
    localparam int FLAG_J = 2;
    localparam int FLAG_M = 3;
    localparam int FLAG_V = 4;
    localparam int FLAG_P = 5;
    localparam int FLAG_T = 6;

    localparam int NUM_STORED_FLAGS = 6;

    localparam int CLR_CYCLES_DEF = 4;
    localparam int PRST_MIN_DEF   = 8;

    typedef enum logic [1:0] {
        PRST_IDLE    = 2'd0,
        PRST_HOLD    = 2'd1,
        PRST_STRETCH = 2'd2
    } prst_state_t;

endpackage

// File: rtl/tube_irq_gen.sv
// Registered interrupt combine for the Tube: merges control flags with buffer
// data-available status; all requests are held low while the FIFO clear runs.
module tube_irq_gen
    import tube_ctrl_flags_pkg::*;
(
    input  logic       h_phi2,
    input  logic       h_rst,
    input  logic       gate,
    input  logic [4:0] flags,
    input  logic       h_r4_avail,
    input  logic       p_r1_avail,
    input  logic       p_r4_avail,
    input  logic       p_r3_avail,
    input  logic       p_r3_two,
    output logic       h_irq,
    output logic       p_irq,
    output logic       p_nmi
);

    logic h_irq_term;
    logic p_irq_term;
    logic p_nmi_term;

    always_comb begin
        h_irq_term = flags[FLAG_Q] & h_r4_avail;
        p_irq_term = (flags[FLAG_I] & p_r1_avail) | (flags[FLAG_J] & p_r4_avail);
        // V selects whether NMI waits for a full two-byte R3 transfer
        p_nmi_term = flags[FLAG_M] & (flags[FLAG_V] ? p_r3_two : p_r3_avail);
    end

    always_ff @(negedge h_phi2 or posedge h_rst) begin
        if (h_rst) begin
            h_irq <= 1'b0;
            p_irq <= 1'b0;
            p_nmi <= 1'b0;
        end else begin
            h_irq <= h_irq_term & ~gate;
            p_irq <= p_irq_term & ~gate;
            p_nmi <= p_nmi_term & ~gate;
        end
    end

endmodule

// File: rtl/tube_ctrl_flags.sv
// Tube host control-flag register, FIFO-clear timer and parasite reset sequencer.
// Define TUBE_PRST_STRETCH_EN to stretch parasite reset to at least PRST_MIN cycles.
module tube_ctrl_flags
    import tube_ctrl_flags_pkg::*;
#(
    parameter int CLR_CYCLES = CLR_CYCLES_DEF,
    parameter int PRST_MIN   = PRST_MIN_DEF
) (
    input  logic       h_phi2,
    input  logic       h_rst,
    input  logic       h_sel_ctrl,
    input  logic       h_we_b,
    input  logic [7:0] h_data,
    input  logic       h_r4_avail,
    input  logic       p_r1_avail,
    input  logic       p_r4_avail,
    input  logic       p_r3_avail,
    input  logic       p_r3_two,
    output logic [6:0] h_status,
    output logic       h_irq,
    output logic       p_irq,
    output logic       p_nmi,
    output logic       p_rst,
    output logic       fifo_clr
);

    if (CLR_CYCLES < 1 || CLR_CYCLES > 15) begin : g_bad_clr
        $error("CLR_CYCLES out of range 1..15");
    end
    if (PRST_MIN < 1 || PRST_MIN > 255) begin : g_bad_prst
        $error("PRST_MIN out of range 1..255");
    end

    logic [NUM_STORED_FLAGS-1:0] flags;
    logic [NUM_STORED_FLAGS-1:0] flags_next;
    logic [3:0]                  clr_cnt;
    logic                        wr;
    logic                        t_write;
    logic                        clr_force;

    assign wr        = h_sel_ctrl & ~h_we_b;
    assign t_write   = wr & h_data[7] & h_data[FLAG_T];
    assign fifo_clr  = (clr_cnt != 4'd0);
    // the T-write edge itself also clears, so flags drop together with fifo_clr rising
    assign clr_force = t_write | fifo_clr;
    assign h_status  = {1'b0, flags};

    always_comb begin
        flags_next = flags;
        if (clr_force) begin
            flags_next[FLAG_V:FLAG_Q] = '0;
        end
        if (wr) begin
            for (int i = 0; i < NUM_STORED_FLAGS; i++) begin
                if (h_data[i]) begin
                    flags_next[i] = h_data[7];
                end
            end
        end
    end

    always_ff @(negedge h_phi2 or posedge h_rst) begin
        if (h_rst) begin
            flags   <= '0;
            clr_cnt <= 4'd0;
        end else begin
            flags <= flags_next;
            if (t_write) begin
                clr_cnt <= 4'(CLR_CYCLES);
            end else if (fifo_clr) begin
                clr_cnt <= clr_cnt - 4'd1;
            end
        end
    end

    tube_irq_gen u_irq_gen (
        .h_phi2     (h_phi2),
        .h_rst      (h_rst),
        .gate       (clr_force),
        .flags      (flags[FLAG_V:FLAG_Q]),
        .h_r4_avail (h_r4_avail),
        .p_r1_avail (p_r1_avail),
        .p_r4_avail (p_r4_avail),
        .p_r3_avail (p_r3_avail),
        .p_r3_two   (p_r3_two),
        .h_irq      (h_irq),
        .p_irq      (p_irq),
        .p_nmi      (p_nmi)
    );

`ifdef TUBE_PRST_STRETCH_EN
    prst_state_t state;
    prst_state_t state_next;
    logic [7:0]  prst_cnt;
    logic [7:0]  prst_cnt_next;
    logic        rst_hold;

    always_comb begin
        state_next    = state;
        prst_cnt_next = prst_cnt;
        case (state)
            PRST_IDLE: begin
                if (flags[FLAG_P]) begin
                    state_next    = PRST_HOLD;
                    prst_cnt_next = 8'(PRST_MIN);
                end
            end
            PRST_HOLD, PRST_STRETCH: begin
                if (flags[FLAG_P]) begin
                    state_next    = PRST_HOLD;
                    prst_cnt_next = 8'(PRST_MIN);
                end else begin
                    prst_cnt_next = (prst_cnt != 8'd0) ? prst_cnt - 8'd1 : 8'd0;
                    state_next    = (prst_cnt <= 8'd1) ? PRST_IDLE : PRST_STRETCH;
                end
            end
            default: begin
                state_next    = PRST_IDLE;
                prst_cnt_next = 8'd0;
            end
        endcase
    end

    always_ff @(negedge h_phi2 or posedge h_rst) begin
        if (h_rst) begin
            state    <= PRST_IDLE;
            prst_cnt <= 8'd0;
            rst_hold <= 1'b1;
        end else begin
            state    <= state_next;
            prst_cnt <= prst_cnt_next;
            rst_hold <= 1'b0;
        end
    end

    // rst_hold keeps the parasite in reset while h_rst is asserted
    assign p_rst = rst_hold | (state != PRST_IDLE);
`else
    logic p_rst_q;

    always_ff @(negedge h_phi2 or posedge h_rst) begin
        if (h_rst) begin
            p_rst_q <= 1'b1;
        end else begin
            p_rst_q <= flags[FLAG_P];
        end
    end

    assign p_rst = p_rst_q;
`endif

endmodule

// File: tb/tb_tube_ctrl_flags.sv
// Scoreboard bench for tube_ctrl_flags: directed scenarios then random traffic,
// expected outputs come from a behavioural model pushed into a queue.
module tb_tube_ctrl_flags;

    localparam int CLR  = 4;
    localparam int PRST = 8;
`ifdef TUBE_PRST_STRETCH_EN
    localparam int PW = PRST;
`else
    localparam int PW = 1;
`endif

    logic       h_phi2 = 1'b1;
    logic       h_rst;
    logic       h_sel_ctrl;
    logic       h_we_b;
    logic [7:0] h_data;
    logic       h_r4_avail, p_r1_avail, p_r4_avail, p_r3_avail, p_r3_two;
    logic [6:0] h_status;
    logic       h_irq, p_irq, p_nmi, p_rst, fifo_clr;

    tube_ctrl_flags #(.CLR_CYCLES(CLR), .PRST_MIN(PRST)) dut (
        .h_phi2     (h_phi2),
        .h_rst      (h_rst),
        .h_sel_ctrl (h_sel_ctrl),
        .h_we_b     (h_we_b),
        .h_data     (h_data),
        .h_r4_avail (h_r4_avail),
        .p_r1_avail (p_r1_avail),
        .p_r4_avail (p_r4_avail),
        .p_r3_avail (p_r3_avail),
        .p_r3_two   (p_r3_two),
        .h_status   (h_status),
        .h_irq      (h_irq),
        .p_irq      (p_irq),
        .p_nmi      (p_nmi),
        .p_rst      (p_rst),
        .fifo_clr   (fifo_clr)
    );

    always #5 h_phi2 = ~h_phi2;

    typedef struct packed {
        logic [6:0] status;
        logic       h_irq;
        logic       p_irq;
        logic       p_nmi;
        logic       p_rst;
        logic       fifo_clr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // model state: stored flags, edges since last T-write, history of P after each edge
    logic [5:0] m_flags;
    int         m_since_t;
    bit         m_phist[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_edge(output exp_t e);
        logic       wr, t, frc;
        logic [5:0] old;
        e = '0;
        if (h_rst) begin
            m_flags   = '0;
            m_since_t = 1000;
            m_phist.delete();
            e.p_rst   = 1'b1;
            return;
        end
        old = m_flags;
        wr  = h_sel_ctrl && !h_we_b;
        t   = wr && h_data[7] && h_data[6];
        frc = (m_since_t < CLR) || t;
        if (!frc) begin
            e.h_irq = old[0] && h_r4_avail;
            e.p_irq = (old[1] && p_r1_avail) || (old[2] && p_r4_avail);
            e.p_nmi = old[3] && (old[4] ? p_r3_two : p_r3_avail);
        end
        if (frc) m_flags[4:0] = '0;
        if (wr) begin
            for (int i = 0; i < 6; i++) if (h_data[i]) m_flags[i] = h_data[7];
        end
        m_since_t  = t ? 0 : ((m_since_t < 1000) ? m_since_t + 1 : 1000);
        e.fifo_clr = (m_since_t < CLR);
        // parasite reset is high if P was set after any of the last PW edges
        e.p_rst = 1'b0;
        for (int k = 0; k < PW && k < m_phist.size(); k++) begin
            if (m_phist[m_phist.size() - 1 - k]) e.p_rst = 1'b1;
        end
        m_phist.push_back(m_flags[5]);
        if (m_phist.size() > 300) void'(m_phist.pop_front());
        e.status = {1'b0, m_flags};
    endtask

    task automatic step();
        exp_t e;
        model_edge(e);
        exp_q.push_back(e);
        @(posedge h_phi2);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [7:0] d);
        h_sel_ctrl = 1'b1;
        h_we_b     = 1'b0;
        h_data     = d;
        step();
        h_sel_ctrl = 1'b0;
        h_we_b     = 1'b1;
        h_data     = 8'($urandom);
    endtask

    task automatic async_reset();
        h_rst = 1'b1;
        #1;
        chk("async_status", 8'(h_status), 8'h00);
        chk("async_h_irq", 8'(h_irq), 8'h00);
        chk("async_p_irq", 8'(p_irq), 8'h00);
        chk("async_p_nmi", 8'(p_nmi), 8'h00);
        chk("async_fifo_clr", 8'(fifo_clr), 8'h00);
        chk("async_p_rst", 8'(p_rst), 8'h01);
        step();
        step();
        h_rst = 1'b0;
        step();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge h_phi2);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("h_status", 8'(h_status), 8'(e.status));
                chk("h_irq", 8'(h_irq), 8'(e.h_irq));
                chk("p_irq", 8'(p_irq), 8'(e.p_irq));
                chk("p_nmi", 8'(p_nmi), 8'(e.p_nmi));
                chk("p_rst", 8'(p_rst), 8'(e.p_rst));
                chk("fifo_clr", 8'(fifo_clr), 8'(e.fifo_clr));
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: run did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [7:0] d;
        h_rst = 1'b1;
        h_sel_ctrl = 1'b0; h_we_b = 1'b1; h_data = 8'h00;
        h_r4_avail = 1'b0; p_r1_avail = 1'b0; p_r4_avail = 1'b0;
        p_r3_avail = 1'b0; p_r3_two = 1'b0;
        m_flags = '0; m_since_t = 1000;
        @(posedge h_phi2);
        #1;
        chk("reset_p_rst", 8'(p_rst), 8'h01);
        chk("reset_status", 8'(h_status), 8'h00);
        step();
        h_rst = 1'b0;
        step();

        // set/clear protocol
        wr(8'h83); wr(8'h02); idle(1); wr(8'h9F); idle(1); wr(8'h1F); idle(1);
        // host IRQ from Q and R4
        wr(8'h81); idle(1); h_r4_avail = 1'b1; idle(2); wr(8'h01); idle(2); h_r4_avail = 1'b0;
        // NMI selection by V
        wr(8'h98); p_r3_avail = 1'b1; idle(2); p_r3_two = 1'b1; idle(2); wr(8'h10); idle(2);
        // FIFO clear pulse and extension
        wr(8'h9F); p_r1_avail = 1'b1; p_r4_avail = 1'b1; idle(2);
        wr(8'hC0); idle(6);
        wr(8'h9F); idle(1); wr(8'hC0); idle(1); wr(8'hC0); idle(7);
        wr(8'h9F); wr(8'hC0); wr(8'h86); idle(6);
        // parasite reset and stretch
        wr(8'hA0); idle(3); wr(8'h20); idle(10);
        wr(8'hA0); idle(2); wr(8'h20); idle(3); wr(8'hA0); idle(3); wr(8'h20); idle(12);
        // reset mid-pulse and mid-stretch
        wr(8'h9F); wr(8'hC0); idle(1); async_reset(); idle(2);
        wr(8'hA0); idle(2); wr(8'h20); idle(2); async_reset(); idle(3);

        for (int n = 0; n < 1500; n++) begin
            h_r4_avail = 1'($urandom); p_r1_avail = 1'($urandom);
            p_r4_avail = 1'($urandom); p_r3_avail = 1'($urandom);
            p_r3_two   = 1'($urandom);
            if ($urandom_range(99) == 0) begin
                h_rst = 1'b1; step(); h_rst = 1'b0;
            end
            if ($urandom_range(2) == 0) begin
                d = 8'($urandom);
                if ($urandom_range(7) != 0) d[6] = 1'b0;
                wr(d);
            end else begin
                step();
            end
        end

        repeat (3) @(posedge h_phi2);
        #1;
        chk("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
